// File: rtl/dram_read_pkg.sv
// -----------------------------------------------------------------------------
// dram_read_pkg
//   Shared defaults and index types for the DRAM read reorder path.
//   DATA_WIDTH  : cache-line width in bits
//   BUFFER_SIZE : read-buffer slot count (power of two, >= 2)
//   ADDR_WIDTH  : request address width
//   slot_idx_t  : buffer slot index / DRAM tag
//   count_t     : occupancy count, one bit wider so "full" is representable
// -----------------------------------------------------------------------------
package dram_read_pkg;

  localparam int DATA_WIDTH  = 512;
  localparam int BUFFER_SIZE = 128;
  localparam int ADDR_WIDTH  = 32;

  localparam int SLOT_W = $clog2(BUFFER_SIZE);

  typedef logic [SLOT_W-1:0] slot_idx_t;
  typedef logic [SLOT_W:0]   count_t;

endpackage

// File: rtl/read_reorder_ctrl_slot_scoreboard.sv
// -----------------------------------------------------------------------------
// slot_scoreboard
//   Per-slot lifecycle tracking for the read reorder buffer:
//   free -> pending (alloc) -> ready (fill) -> free (release).
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_alloc_en/_idx        : slot handed to a new DRAM request
//   i_fill_en/_idx         : DRAM response strobe and its tag
//   i_rel_en/_idx          : slot drained by the consumer
//   o_fill_ok              : response hits a pending slot (buffer write enable)
//   o_rel_ready            : slot at i_rel_idx holds a returned line
//   o_err_spurious         : sticky, a response hit a non-pending slot
// -----------------------------------------------------------------------------
module slot_scoreboard
  import dram_read_pkg::*;
#(
  parameter int BUFFER_SIZE = dram_read_pkg::BUFFER_SIZE,
  localparam int IDX_W      = $clog2(BUFFER_SIZE)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_alloc_en,
  input  logic [IDX_W-1:0] i_alloc_idx,
  input  logic             i_fill_en,
  input  logic [IDX_W-1:0] i_fill_idx,
  input  logic             i_rel_en,
  input  logic [IDX_W-1:0] i_rel_idx,
  output logic             o_fill_ok,
  output logic             o_rel_ready,
  output logic             o_err_spurious
);

  logic [BUFFER_SIZE-1:0] r_pending;
  logic [BUFFER_SIZE-1:0] r_ready;
  logic                   r_err_spurious;

  assign o_fill_ok      = i_fill_en && r_pending[i_fill_idx];
  assign o_rel_ready    = r_ready[i_rel_idx];
  assign o_err_spurious = r_err_spurious;

  // Alloc targets a free slot, fill a pending one, release a ready one, so
  // the three updates below never touch the same bit in one cycle.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      r_pending      <= '0;
      r_ready        <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      if (i_alloc_en) r_pending[i_alloc_idx] <= 1'b1;
      if (o_fill_ok) begin
        r_pending[i_fill_idx] <= 1'b0;
        r_ready[i_fill_idx]   <= 1'b1;
      end
      if (i_fill_en && !r_pending[i_fill_idx]) r_err_spurious <= 1'b1;
      if (i_rel_en) r_ready[i_rel_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/read_reorder_ctrl.sv
// -----------------------------------------------------------------------------
// read_reorder_ctrl
//   Allocates one read-buffer slot per cache-line request in order, issues the
//   request to DRAM tagged with that slot, steers out-of-order responses into
//   the buffer by tag, and releases lines to the consumer in request order.
//   The data store itself is the read buffer instantiated in the parent.
//   i_clk, i_reset                  : clock, synchronous active-high reset
//   i_req_valid/o_req_ready/i_req_addr        : request in from cache
//   o_mem_req_valid/i_mem_req_ready           : DRAM request handshake
//   o_mem_req_addr/o_mem_req_tag              : registered DRAM request
//   i_mem_resp_valid/_tag/_data               : DRAM response (no backpressure)
//   o_buf_write_en/_addr, o_buf_data_in       : buffer write port
//   o_buf_read_addr, i_buf_data_out           : buffer read port (head slot)
//   o_out_valid/i_out_ready/o_out_data        : in-order delivery to consumer
//   o_err_spurious                            : sticky spurious-response flag
// -----------------------------------------------------------------------------
module read_reorder_ctrl
  import dram_read_pkg::*;
#(
  parameter int DATA_WIDTH  = dram_read_pkg::DATA_WIDTH,
  parameter int BUFFER_SIZE = dram_read_pkg::BUFFER_SIZE,
  parameter int ADDR_WIDTH  = dram_read_pkg::ADDR_WIDTH,
  localparam int IDX_W      = $clog2(BUFFER_SIZE),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [IDX_W-1:0]      o_mem_req_tag,
  input  logic                  i_mem_resp_valid,
  input  logic [IDX_W-1:0]      i_mem_resp_tag,
  input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
  output logic                  o_buf_write_en,
  output logic [IDX_W-1:0]      o_buf_write_addr,
  output logic [DATA_WIDTH-1:0] o_buf_data_in,
  output logic [IDX_W-1:0]      o_buf_read_addr,
  input  logic [DATA_WIDTH-1:0] i_buf_data_out,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_err_spurious
);

  logic [IDX_W-1:0]      r_head;
  logic [IDX_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_mem_req_valid;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic [IDX_W-1:0]      r_mem_req_tag;

  logic w_full;
  logic w_req_ready;
  logic w_accept;
  logic w_release;
  logic w_head_ready;
  logic w_fill_ok;

  // A full buffer blocks admission even if the head drains this cycle; this
  // keeps req_ready free of any combinational path from i_out_ready.
  assign w_full      = (r_count == CNT_W'(BUFFER_SIZE));
  assign w_req_ready = !w_full && (!r_mem_req_valid || i_mem_req_ready);
  assign w_accept    = i_req_valid && w_req_ready;
  assign w_release   = w_head_ready && i_out_ready;

  slot_scoreboard #(
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_slot_scoreboard (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_alloc_en     (w_accept),
    .i_alloc_idx    (r_tail),
    .i_fill_en      (i_mem_resp_valid),
    .i_fill_idx     (i_mem_resp_tag),
    .i_rel_en       (w_release),
    .i_rel_idx      (r_head),
    .o_fill_ok      (w_fill_ok),
    .o_rel_ready    (w_head_ready),
    .o_err_spurious (o_err_spurious)
  );

  // NOTE: the line buffer is not reset; slot contents are only read once the
  // ready bit is set, and that bit is cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_tag   <= '0;
    end else begin
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_release) r_head <= r_head + 1'b1;

      unique case ({w_accept, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A new load wins over the drain of the previous request.
      if (w_accept) begin
        r_mem_req_valid <= 1'b1;
        r_mem_req_addr  <= i_req_addr;
        r_mem_req_tag   <= r_tail;
      end else if (i_mem_req_ready) begin
        r_mem_req_valid <= 1'b0;
      end
    end
  end

  assign o_req_ready      = w_req_ready;
  assign o_mem_req_valid  = r_mem_req_valid;
  assign o_mem_req_addr   = r_mem_req_addr;
  assign o_mem_req_tag    = r_mem_req_tag;
  assign o_buf_write_en   = w_fill_ok;
  assign o_buf_write_addr = i_mem_resp_tag;
  assign o_buf_data_in    = i_mem_resp_data;
  assign o_buf_read_addr  = r_head;
  assign o_out_valid      = w_head_ready;
  assign o_out_data       = i_buf_data_out;

endmodule
